// File: rtl/seq_restoring_div_if.sv
// ============================================================================
//  Module      : seq_restoring_div_if
//  Description : Operand/result handshake bundle for seq_restoring_div.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_restoring_div_if #(
    parameter int W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/seq_restoring_div.sv
// ============================================================================
//  Module      : seq_restoring_div
//  Description : Iterative restoring divider, 2W-bit dividend / W-bit divisor,
//                one quotient bit per clock. Optional SEQ_DIV_FAST_ZERO_EN
//                short-circuits zero dividend/divisor straight to DONE.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_restoring_div #(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_restoring_div_if.slave bus
);
    localparam int          STEPS = 2 * W;
    localparam int          CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] c_STEPS = CW'(STEPS);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [2*W-1:0] q_q, q_d;
    logic [W:0]     part_q, part_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dbz_q, dbz_d;

    logic [W:0]     w_shift;
    logic           w_ge;

    // Partial remainder stays below the divisor, so W+1 bits hold the shifted value.
    assign w_shift = {part_q[W-1:0], q_q[2*W-1]};
    assign w_ge    = (w_shift >= {1'b0, dvs_q});

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        part_d  = part_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.in_valid) begin
                    q_d     = bus.dividend;
                    dvs_d   = bus.divisor;
                    part_d  = '0;
                    cnt_d   = c_STEPS;
                    dbz_d   = (bus.divisor == '0);
                    state_d = c_ST_RUN;
`ifdef SEQ_DIV_FAST_ZERO_EN
                    if (bus.divisor == '0) begin
                        q_d     = '1;
                        part_d  = {1'b0, bus.dividend[W-1:0]};
                        cnt_d   = '0;
                        state_d = c_ST_DONE;
                    end else if (bus.dividend == '0) begin
                        q_d     = '0;
                        cnt_d   = '0;
                        state_d = c_ST_DONE;
                    end
`endif
                end
            end
            c_ST_RUN: begin
                if (w_ge) begin
                    part_d = w_shift - {1'b0, dvs_q};
                    q_d    = {q_q[2*W-2:0], 1'b1};
                end else begin
                    part_d = w_shift;
                    q_d    = {q_q[2*W-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_ST_IDLE;
            q_q     <= '0;
            part_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            part_q  <= part_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == c_ST_IDLE);
    assign bus.out_valid   = (state_q == c_ST_DONE);
    assign bus.quotient    = q_q;
    assign bus.remainder   = part_q[W-1:0];
    assign bus.div_by_zero = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_restoring_div.sv
// ============================================================================
//  Module      : tb_seq_restoring_div
//  Description : Scoreboard bench for seq_restoring_div with a plain-arithmetic
//                reference model and random back-to-back traffic.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_restoring_div;
    localparam int W = 4;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W-1:0]   dvs;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dbz;
        int             acc;
        int             lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    bit   prev_hs = 1'b0;
    bit   prev_ov = 1'b0;

    seq_restoring_div_if #(.W(W)) bus ();

    seq_restoring_div #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        e.dvd = a;
        e.dvs = b;
        e.acc = acc;
        e.dbz = (b == 0);
        if (b == 0) begin
            e.q = '1;
            e.r = a[W-1:0];
        end else begin
            e.q = (2*W)'(int'(a) / int'(b));
            e.r = W'(int'(a) % int'(b));
        end
        e.lat = 2*W + 1;
`ifdef SEQ_DIV_FAST_ZERO_EN
        if (a == 0 || b == 0) e.lat = 1;
`endif
        return e;
    endfunction

    // Monitor: samples at the falling edge what the next rising edge will commit.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hs = 1'b0;
            prev_ov = 1'b0;
        end else begin
            if (prev_hs) begin
                check("in_ready_after_hs", bus.in_ready, 1);
                check("out_valid_after_hs", bus.out_valid, 0);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t h;
                    h = exp_q[0];
                    if (!prev_ov) check("latency", cyc - h.acc + 1, h.lat);
                    check("quotient", bus.quotient, h.q);
                    check("remainder", bus.remainder, h.r);
                    check("div_by_zero", bus.div_by_zero, h.dbz);
                    check("in_ready_in_done", bus.in_ready, 0);
                    if (bus.out_ready) begin
                        if (h.dvs != 0) begin
                            check("q*d+r", longint'(bus.quotient) * h.dvs + bus.remainder, h.dvd);
                            check("r<d", longint'(bus.remainder < h.dvs), 1);
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(bus.dividend, bus.divisor, cyc + 1));
            prev_hs = bus.out_valid && bus.out_ready;
            prev_ov = bus.out_valid;
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic do_op(input logic [2*W-1:0] a, input logic [W-1:0] b, input bit hold);
        int n;
        n = 0;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            n++;
            if (bus.in_ready || n > 100) break;
        end
        if (n > 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if ((exp_q.size() == 0 && bus.in_ready) || n > 200) break;
        end
        if (n > 200) check("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        do_op(8'd225, 4'd15, 0); wait_idle();
        do_op(8'd200, 4'd7, 0);  wait_idle();
        do_op(8'd255, 4'd1, 0);  wait_idle();
        do_op(8'hA5, 4'd0, 0);   wait_idle();
        do_op(8'd0, 4'd5, 0);    wait_idle();

        // Backpressure: hold the result for 5 cycles.
        bus.out_ready = 1'b0;
        do_op(8'd100, 4'd9, 0);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.out_valid || n > 100) break;
        end
        if (n > 100) check("bp_valid_timeout", 0, 1);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_idle();

        // Reset three cycles into RUN aborts the operation.
        do_op(8'd200, 4'd7, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op(8'd50, 4'd6, 0);
        wait_idle();

        // Back-to-back random traffic with in_valid held high.
        do_op(8'd255, 4'd15, 1);
        do_op(8'd0, 4'd0, 1);
        for (int i = 0; i < 60; i++) begin
            do_op((2*W)'($urandom_range(0, 255)), W'($urandom_range(0, 15)), 1);
        end
        bus.in_valid = 1'b0;
        wait_idle();
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
